decoder_pulse_seq: RTL and testbench
====================================

# decoder_pulse_seq

Sequential 4-to-16 one-hot decoder, the output-side counterpart of the block's 16-to-4 binary encoder. It accepts a 4-bit code through a valid/ready handshake and drives the matching one-hot line on `decoder_out` for a fixed number of cycles. It then forces one all-zero gap cycle before accepting the next code. It sits between a control block that issues binary select codes and 16 single-line enables, so back-to-back identical codes remain distinguishable.

## Interface
- `HOLD_CYCLES`, default 4: cycles each one-hot pattern is held. Legal range 1..255.
- `clk`  in  1  clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `enable`  in  1  block enable; low prevents accepts and aborts an active hold.
- `binary_in`  in  4  code to decode; sampled only on accept.
- `in_valid`  in  1  `binary_in` is valid.
- `in_ready`  out  1  the block can accept this cycle.
- `decoder_out`  out  16  registered one-hot output; all-zero when not holding.
- `out_valid`  out  1  high exactly while `decoder_out` is non-zero.
- `busy`  out  1  high in HOLD or GAP.

## Operation
- States:
  - IDLE: waits for a code.
  - HOLD: drives the one-hot pattern.
  - GAP: drives one all-zero cycle.
- Accept = `in_valid & in_ready`.
- `in_ready` = (state == IDLE) & `enable` & !`reset`. It is combinational and does not depend on `in_valid`.
- IDLE, on accept:
  - `decoder_out` <= 16'h0001 << `binary_in`. Code 0 maps to 16'h0001, code 15 to 16'h8000.
  - hold counter <= HOLD_CYCLES-1.
  - Next state is HOLD.
- IDLE, no accept: outputs stay zero.
- HOLD with `enable`=1:
  - Counter != 0: decrement, pattern unchanged.
  - Counter == 0: `decoder_out` <= 0, next state GAP.
- HOLD with `enable`=0: `decoder_out` <= 0 at the next edge, counter <= 0, next state IDLE. No GAP cycle on abort.
- GAP: always returns to IDLE at the next edge, whatever `enable` is.
- Hold counter is 8 bits wide and never wraps below 0.
- Reset values:
  - state = IDLE
  - `decoder_out` = 16'h0000
  - `out_valid` = 0
  - `busy` = 0
  - counter = 0
  - `in_ready` = 0 while `reset` is high.
- Reset during HOLD or GAP: the output clears asynchronously and no pattern resumes after release.
- `decoder_out` is never multi-hot. It is either zero or exactly one bit set.
- `binary_in` changes while not accepting have no effect.

## Timing
- Accept at rising edge N: pattern visible from just after edge N through edge N+HOLD_CYCLES.
  - `out_valid` is high for exactly HOLD_CYCLES cycles.
- Edge N+HOLD_CYCLES: output goes to zero (GAP).
- Edge N+HOLD_CYCLES+1: back in IDLE; `in_ready` goes high in the same cycle if `enable`=1.
- Earliest next accept is edge N+HOLD_CYCLES+2.
  - With `in_valid` held high, accepts occur every HOLD_CYCLES+2 cycles.
- HOLD_CYCLES=1 gives a pattern one cycle wide, followed by one GAP cycle.
- An `enable` fall during HOLD is acted on at the next edge. `in_ready` stays low until the cycle after that edge.
- `out_valid` and `busy` are registered or decoded from registered state only, with no input-to-output combinational path.

## Test plan
- Reset then code sweep: apply and release `reset`, then present codes 0..15 with `in_valid` held high and HOLD_CYCLES=4.
  - Each code produces `decoder_out` = 1<<code for 4 cycles, then 1 zero cycle.
  - Accepts occur every 6 cycles; `decoder_out` is never multi-hot.
- Back-to-back identical code: present code 5 twice, HOLD_CYCLES=1.
  - `decoder_out` sequence is 16'h0020, 0, then IDLE cycle 0, then 16'h0020.
  - Exactly one zero cycle of GAP separates the two patterns.
- Abort: accept code 9, drop `enable` on the 2nd HOLD cycle.
  - 16'h0200 is seen for 2 cycles, then 0 at the next edge.
  - State returns directly to IDLE, with `in_ready`=0 until `enable` returns.
- Asynchronous reset mid-hold: accept code 15, assert `reset` between edges on the 3rd hold cycle.
  - `decoder_out`=0 and `busy`=0 before the next edge.
  - After release there is no output until a new accept.
- Handshake gating: `in_valid`=1 with `enable`=0 for 10 cycles, then `enable`=1.
  - No accept and no output during the 10 cycles.
  - Accept occurs on the first edge with `enable`=1, and the output appears one cycle later.
- Bound: HOLD_CYCLES=255, code 0.
  - 16'h0001 is held for exactly 255 cycles, then the GAP cycle.
  - The counter does not wrap.

Source files
------------

// File: rtl/decoder_pulse_seq.sv
// decoder_pulse_seq: sequential 4-to-16 one-hot decoder with a fixed hold time
// followed by one forced all-zero gap cycle, so repeated identical codes stay
// distinguishable on the enable lines downstream.
module decoder_pulse_seq #(
   parameter int HOLD_CYCLES = 4  // 1..255
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_enable,
   input  logic [3:0]  i_binary_in,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   output logic [15:0] o_decoder_out,
   output logic        o_out_valid,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   // Counter starts at HOLD_CYCLES-1 so the pattern lasts exactly HOLD_CYCLES cycles.
   localparam logic [7:0] LP_CNT_INIT = 8'(HOLD_CYCLES - 1);

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_cnt;
   logic [15:0] r_dout;
   logic        w_ready;
   logic        w_accept;

   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state logic; an enable drop in HOLD skips the gap and goes straight to IDLE
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_accept) w_next = S_HOLD;
         S_HOLD: begin
            if (!i_enable)          w_next = S_IDLE;
            else if (r_cnt == 8'd0) w_next = S_GAP;
         end
         S_GAP:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs decoded from registered state only, except in_ready which gates on enable/reset
   always_comb begin
      w_ready       = (r_state == S_IDLE) & i_enable & ~i_reset;
      w_accept      = i_in_valid & w_ready;
      o_in_ready    = w_ready;
      o_busy        = (r_state != S_IDLE);
      o_out_valid   = |r_dout;
      o_decoder_out = r_dout;
   end

   // Pattern and hold counter; pattern is loaded only on accept so later binary_in changes are ignored
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt  <= 8'd0;
         r_dout <= 16'h0000;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_dout <= 16'h0001 << i_binary_in;
                  r_cnt  <= LP_CNT_INIT;
               end else begin
                  r_dout <= 16'h0000;
                  r_cnt  <= 8'd0;
               end
            end
            S_HOLD: begin
               if (!i_enable) begin
                  r_dout <= 16'h0000;
                  r_cnt  <= 8'd0;
               end else if (r_cnt != 8'd0) begin
                  r_cnt  <= r_cnt - 8'd1;
               end else begin
                  r_dout <= 16'h0000;
               end
            end
            default: begin
               r_dout <= 16'h0000;
               r_cnt  <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_pulse_seq.sv
// Bench for decoder_pulse_seq: three instances (HOLD_CYCLES 4, 1, 255) share
// inputs; each scenario task checks the instance it targets.
module tb_decoder_pulse_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, vld;
   logic [3:0]  code;
   logic        rdy_a, rdy_b, rdy_c;
   logic [15:0] dout_a, dout_b, dout_c;
   logic        ov_a, ov_b, ov_c;
   logic        busy_a, busy_b, busy_c;

   decoder_pulse_seq #(.HOLD_CYCLES(4)) u_a (
      .i_clk(clk), .i_reset(rst), .i_enable(en), .i_binary_in(code), .i_in_valid(vld),
      .o_in_ready(rdy_a), .o_decoder_out(dout_a), .o_out_valid(ov_a), .o_busy(busy_a));
   decoder_pulse_seq #(.HOLD_CYCLES(1)) u_b (
      .i_clk(clk), .i_reset(rst), .i_enable(en), .i_binary_in(code), .i_in_valid(vld),
      .o_in_ready(rdy_b), .o_decoder_out(dout_b), .o_out_valid(ov_b), .o_busy(busy_b));
   decoder_pulse_seq #(.HOLD_CYCLES(255)) u_c (
      .i_clk(clk), .i_reset(rst), .i_enable(en), .i_binary_in(code), .i_in_valid(vld),
      .o_in_ready(rdy_c), .o_decoder_out(dout_c), .o_out_valid(ov_c), .o_busy(busy_c));

   typedef struct packed {
      logic [15:0] dout;
      logic        rdy;
      logic        busy;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;

   // Pulse reset and leave all instances idle, at a falling edge.
   task automatic do_reset();
      en = 1'b0; vld = 1'b0; code = 4'd0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; vld = 1'b1; code = 4'd3;
      repeat (2) @(negedge clk);
      checks++; if ({dout_a, dout_b, dout_c} !== 48'h0) begin failures++;
         $display("FAIL reset_dout: got %h want 0", {dout_a, dout_b, dout_c}); end
      checks++; if ({ov_a, ov_b, ov_c, busy_a, busy_b, busy_c} !== 6'b0) begin failures++;
         $display("FAIL reset_ov_busy: got %b want 000000", {ov_a, ov_b, ov_c, busy_a, busy_b, busy_c}); end
      checks++; if ({rdy_a, rdy_b, rdy_c} !== 3'b000) begin failures++;
         $display("FAIL reset_ready: got %b want 000", {rdy_a, rdy_b, rdy_c}); end
      vld = 1'b0; rst = 1'b0; #1;
      checks++; if ({rdy_a, rdy_b, rdy_c} !== 3'b111) begin failures++;
         $display("FAIL reset_release_ready: got %b want 111", {rdy_a, rdy_b, rdy_c}); end
   endtask

   // All 16 codes back to back on the HOLD_CYCLES=4 instance with in_valid held high.
   task automatic test_sweep();
      exp_t e;
      int   waited, n;
      do_reset();
      en = 1'b1; vld = 1'b1;
      for (int c = 0; c < 16; c++) begin
         #1;
         waited = 0;
         while (!rdy_a && waited < 20) begin @(negedge clk); #1; waited++; end
         checks++; if (waited >= 20) begin failures++;
            $display("FAIL sweep_ready_timeout: code %0d got ready=%b want 1", c, rdy_a); end
         if (c > 0) begin
            checks++; if (waited != 0) begin failures++;
               $display("FAIL sweep_spacing: code %0d got extra wait %0d want 0", c, waited); end
         end
         code = 4'(c);
         for (int k = 0; k < 4; k++) sbq.push_back('{dout: 16'h0001 << c, rdy: 1'b0, busy: 1'b1});
         sbq.push_back('{dout: 16'h0000, rdy: 1'b0, busy: 1'b1});
         sbq.push_back('{dout: 16'h0000, rdy: 1'b1, busy: 1'b0});
         n = sbq.size();
         for (int k = 0; k < n; k++) begin
            @(negedge clk);
            e = sbq.pop_front();
            checks++; if (dout_a !== e.dout) begin failures++;
               $display("FAIL sweep_dout: code %0d cyc %0d got %h want %h", c, k, dout_a, e.dout); end
            checks++; if (ov_a !== (|e.dout)) begin failures++;
               $display("FAIL sweep_out_valid: code %0d cyc %0d got %b want %b", c, k, ov_a, |e.dout); end
            checks++; if ({rdy_a, busy_a} !== {e.rdy, e.busy}) begin failures++;
               $display("FAIL sweep_rdy_busy: code %0d cyc %0d got %b want %b", c, k, {rdy_a, busy_a}, {e.rdy, e.busy}); end
            checks++; if ($countones(dout_a) > 1) begin failures++;
               $display("FAIL sweep_onehot: code %0d got %h want at most one bit", c, dout_a); end
            code = 4'($urandom_range(0, 15));  // must not disturb the held pattern
         end
      end
      vld = 1'b0;
   endtask

   // Code 5 twice on the HOLD_CYCLES=1 instance: pattern, gap, idle, pattern.
   task automatic test_back_to_back();
      exp_t e;
      int   waited, n;
      do_reset();
      en = 1'b1; vld = 1'b1; code = 4'd5; #1;
      waited = 0;
      while (!rdy_b && waited < 20) begin @(negedge clk); #1; waited++; end
      checks++; if (waited >= 20) begin failures++;
         $display("FAIL b2b_ready_timeout: got ready=%b want 1", rdy_b); end
      sbq.push_back('{dout: 16'h0020, rdy: 1'b0, busy: 1'b1});
      sbq.push_back('{dout: 16'h0000, rdy: 1'b0, busy: 1'b1});
      sbq.push_back('{dout: 16'h0000, rdy: 1'b1, busy: 1'b0});
      sbq.push_back('{dout: 16'h0020, rdy: 1'b0, busy: 1'b1});
      n = sbq.size();
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         e = sbq.pop_front();
         checks++; if (dout_b !== e.dout) begin failures++;
            $display("FAIL b2b_dout: cyc %0d got %h want %h", k, dout_b, e.dout); end
         checks++; if ({rdy_b, busy_b} !== {e.rdy, e.busy}) begin failures++;
            $display("FAIL b2b_rdy_busy: cyc %0d got %b want %b", k, {rdy_b, busy_b}, {e.rdy, e.busy}); end
      end
      vld = 1'b0;
   endtask

   // Drop enable in the 2nd hold cycle of code 9: no gap, ready stays low until enable returns.
   task automatic test_abort();
      exp_t e;
      int   waited, n;
      do_reset();
      en = 1'b1; vld = 1'b1; code = 4'd9; #1;
      waited = 0;
      while (!rdy_a && waited < 20) begin @(negedge clk); #1; waited++; end
      checks++; if (waited >= 20) begin failures++;
         $display("FAIL abort_ready_timeout: got ready=%b want 1", rdy_a); end
      sbq.push_back('{dout: 16'h0200, rdy: 1'b0, busy: 1'b1});
      sbq.push_back('{dout: 16'h0200, rdy: 1'b0, busy: 1'b1});
      for (int k = 0; k < 3; k++) sbq.push_back('{dout: 16'h0000, rdy: 1'b0, busy: 1'b0});
      n = sbq.size();
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         e = sbq.pop_front();
         checks++; if (dout_a !== e.dout) begin failures++;
            $display("FAIL abort_dout: cyc %0d got %h want %h", k, dout_a, e.dout); end
         checks++; if ({rdy_a, busy_a} !== {e.rdy, e.busy}) begin failures++;
            $display("FAIL abort_rdy_busy: cyc %0d got %b want %b", k, {rdy_a, busy_a}, {e.rdy, e.busy}); end
         if (k == 0) vld = 1'b0;
         if (k == 1) en = 1'b0;
      end
      en = 1'b1; #1;
      checks++; if ({rdy_a, dout_a} !== {1'b1, 16'h0000}) begin failures++;
         $display("FAIL abort_reenable: got rdy=%b dout=%h want rdy=1 dout=0000", rdy_a, dout_a); end
   endtask

   // Reset asserted between edges in the 3rd hold cycle of code 15.
   task automatic test_async_reset();
      int waited;
      do_reset();
      en = 1'b1; vld = 1'b1; code = 4'd15; #1;
      waited = 0;
      while (!rdy_a && waited < 20) begin @(negedge clk); #1; waited++; end
      checks++; if (waited >= 20) begin failures++;
         $display("FAIL arst_ready_timeout: got ready=%b want 1", rdy_a); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         vld = 1'b0;
         checks++; if (dout_a !== 16'h8000) begin failures++;
            $display("FAIL arst_hold_dout: cyc %0d got %h want 8000", k, dout_a); end
      end
      rst = 1'b1; #1;
      checks++; if ({dout_a, ov_a, busy_a, rdy_a} !== 19'h0) begin failures++;
         $display("FAIL arst_immediate: got dout=%h ov=%b busy=%b rdy=%b want all 0", dout_a, ov_a, busy_a, rdy_a); end
      @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++; if ({dout_a, busy_a} !== 17'h0) begin failures++;
            $display("FAIL arst_no_resume: cyc %0d got dout=%h busy=%b want 0", k, dout_a, busy_a); end
      end
      code = 4'd3; vld = 1'b1;
      @(negedge clk); vld = 1'b0;
      checks++; if (dout_a !== 16'h0008) begin failures++;
         $display("FAIL arst_new_accept: got %h want 0008", dout_a); end
   endtask

   // in_valid high with enable low for 10 cycles, then enable: accept on the first enabled edge.
   task automatic test_gating();
      do_reset();
      en = 1'b0; vld = 1'b1; code = 4'd7;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++; if ({rdy_a, busy_a, dout_a} !== 18'h0) begin failures++;
            $display("FAIL gate_blocked: cyc %0d got rdy=%b busy=%b dout=%h want 0", k, rdy_a, busy_a, dout_a); end
      end
      en = 1'b1; #1;
      checks++; if (rdy_a !== 1'b1) begin failures++;
         $display("FAIL gate_ready: got %b want 1", rdy_a); end
      @(negedge clk); vld = 1'b0;
      checks++; if ({dout_a, ov_a} !== {16'h0080, 1'b1}) begin failures++;
         $display("FAIL gate_output: got dout=%h ov=%b want 0080 1", dout_a, ov_a); end
   endtask

   // HOLD_CYCLES=255, code 0: 255 pattern cycles, gap, idle, then quiet.
   task automatic test_bound();
      exp_t e;
      int   waited, n;
      do_reset();
      en = 1'b1; vld = 1'b1; code = 4'd0; #1;
      waited = 0;
      while (!rdy_c && waited < 20) begin @(negedge clk); #1; waited++; end
      checks++; if (waited >= 20) begin failures++;
         $display("FAIL bound_ready_timeout: got ready=%b want 1", rdy_c); end
      for (int k = 0; k < 255; k++) sbq.push_back('{dout: 16'h0001, rdy: 1'b0, busy: 1'b1});
      sbq.push_back('{dout: 16'h0000, rdy: 1'b0, busy: 1'b1});
      sbq.push_back('{dout: 16'h0000, rdy: 1'b1, busy: 1'b0});
      n = sbq.size();
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         vld = 1'b0;
         e = sbq.pop_front();
         checks++; if ({dout_c, rdy_c, busy_c} !== {e.dout, e.rdy, e.busy}) begin failures++;
            $display("FAIL bound_seq: cyc %0d got dout=%h rdy=%b busy=%b want %h %b %b",
                     k, dout_c, rdy_c, busy_c, e.dout, e.rdy, e.busy); end
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++; if ({dout_c, busy_c} !== 17'h0) begin failures++;
            $display("FAIL bound_quiet: cyc %0d got dout=%h busy=%b want 0", k, dout_c, busy_c); end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; vld = 1'b0; code = 4'd0;
      test_reset();
      test_sweep();
      test_back_to_back();
      test_abort();
      test_async_reset();
      test_gating();
      test_bound();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
